// File: rtl/prime_pkg.sv
// Shared types and constants for the 4-bit prime scan sequencer.
package prime_pkg;

    // Sequencer states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit i set means value i is prime: 2, 3, 5, 7, 11, 13.
    localparam logic [15:0] PRIME_MASK = 16'h28AC;

endpackage

// File: rtl/prime4_check.sv
// Combinational primality test for a 4-bit value using a lookup mask.
module prime4_check
    import prime_pkg::*;
(
    input  logic [3:0] val,
    output logic       isprime
);

    assign isprime = PRIME_MASK[val];

endmodule

// File: rtl/prime_scan_ctrl.sv
// Sweeps [lo, hi] one value per cycle, streams each prime over a
// valid/ready port, then reports a prime count and a one-cycle done pulse.
//
// Handshake: out_valid rises with out_data already stable and both stay
// unchanged until a rising edge where out_valid && out_ready are both high;
// that edge is the transfer. out_valid never depends on out_ready in the same
// cycle, and out_ready is ignored whenever out_valid is low.
module prime_scan_ctrl
    import prime_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       lo,
    input  logic [3:0]       hi,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [CNT_W-1:0] prime_cnt,
    output logic             done,
    output logic             err,
    output logic [1:0]       dbg_state
);

    state_t     state;
    state_t     state_n;
    logic [3:0] cur;
    logic [3:0] hi_q;
    logic       isprime;

    // Control strobes decoded from the current state.
    logic load;
    logic fail_start;
    logic inc_cur;
    logic emit;
    logic xfer;

    prime4_check u_check (
        .val     (cur),
        .isprime (isprime)
    );

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and control decode; end-of-range test precedes any increment.
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        fail_start = 1'b0;
        inc_cur    = 1'b0;
        emit       = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (lo <= hi) begin
                        load    = 1'b1;
                        state_n = SCAN;
                    end else begin
                        fail_start = 1'b1;
                        state_n    = DONE;
                    end
                end
            end
            SCAN: begin
                if (isprime) begin
                    emit    = 1'b1;
                    state_n = EMIT;
                end else if (cur == hi_q) begin
                    state_n = DONE;
                end else begin
                    inc_cur = 1'b1;
                end
            end
            EMIT: begin
                // out_valid is high for the whole of EMIT, so ready alone marks a transfer.
                if (out_ready) begin
                    xfer = 1'b1;
                    if (cur == hi_q) begin
                        state_n = DONE;
                    end else begin
                        inc_cur = 1'b1;
                        state_n = SCAN;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= 4'd0;
            hi_q      <= 4'd0;
            out_data  <= 4'd0;
            out_valid <= 1'b0;
            prime_cnt <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load) begin
                cur  <= lo;
                hi_q <= hi;
            end else if (inc_cur) begin
                cur <= cur + 4'd1;
            end

            if (load || fail_start) begin
                prime_cnt <= '0;
            end else if (xfer) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
            end

            if (load) begin
                err <= 1'b0;
            end else if (fail_start) begin
                err <= 1'b1;
            end

            if (emit) begin
                out_data  <= cur;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            done <= (state_n == DONE);
            busy <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_prime_scan_ctrl.sv
// Self-checking bench for prime_scan_ctrl: directed scenarios plus random
// ranges and random backpressure against a trial-division reference model.
module tb_prime_scan_ctrl;

    localparam int CNT_W = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       lo;
    logic [3:0]       hi;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [CNT_W-1:0] prime_cnt;
    logic             done;
    logic             err;
    logic [1:0]       dbg_state;

    int checks;
    int failures;

    prime_scan_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .prime_cnt (prime_cnt),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference primality by trial division.
    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Runs one command and checks the stream, timing and final status.
    // mode 0: ready always high; 1: random ready; 2: ready low for the first 5 valid cycles.
    task automatic run_scan(input logic [3:0] l, input logic [3:0] h, input int mode,
                            input int exp_done);
        logic [3:0] exp_q[$];
        logic [3:0] e;
        logic [3:0] held;
        logic       r;
        logic       prev_hold;
        bit         is_err;
        int         n_p, stalls, stall_left, c, done_c, model_done;
        is_err = (l > h);
        exp_q = {};
        for (int v = int'(l); v <= int'(h); v++) begin
            if (is_prime(v)) exp_q.push_back(4'(v));
        end
        n_p        = exp_q.size();
        stalls     = 0;
        stall_left = (mode == 2) ? 5 : 0;
        done_c     = -1;
        prev_hold  = 1'b0;
        held       = 4'd0;
        start      = 1'b1;
        lo         = l;
        hi         = h;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 1;
        while (c <= 300) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_after_start lo=%0d hi=%0d got=%b exp=1", l, h, busy);
                end
                checks++;
                if (err !== is_err) begin
                    failures++;
                    $display("FAIL err_cycle1 lo=%0d hi=%0d got=%b exp=%b", l, h, err, is_err);
                end
            end
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    failures++;
                    $display("FAIL hold_stable lo=%0d hi=%0d valid=%b data=%0d exp_data=%0d",
                             l, h, out_valid, out_data, held);
                end
            end
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            if (mode == 0) begin
                r = 1'b1;
            end else if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
                if (out_valid && stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end
            end
            if (out_valid === 1'b1) begin
                if (r) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL extra_transfer lo=%0d hi=%0d got=%0d exp=none", l, h, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            failures++;
                            $display("FAIL out_data lo=%0d hi=%0d got=%0d exp=%0d", l, h, out_data, e);
                        end
                    end
                end else begin
                    stalls++;
                end
            end
            prev_hold = out_valid && !r;
            held      = out_data;
            out_ready = r;
            c++;
        end
        out_ready = 1'b1;
        model_done = is_err ? 1 : (int'(h) - int'(l) + 1) + n_p + 1 + stalls;
        checks++;
        if (done_c < 0) begin
            failures++;
            $display("FAIL done_timeout lo=%0d hi=%0d got=none exp=%0d", l, h, model_done);
        end else begin
            if (done_c != model_done) begin
                failures++;
                $display("FAIL done_cycle lo=%0d hi=%0d got=%0d exp=%0d", l, h, done_c, model_done);
            end
            if (exp_done >= 0) begin
                checks++;
                if (done_c != exp_done) begin
                    failures++;
                    $display("FAIL done_cycle_fixed lo=%0d hi=%0d got=%0d exp=%0d", l, h, done_c, exp_done);
                end
            end
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL done_status lo=%0d hi=%0d valid=%b busy=%b exp valid=0 busy=1",
                         l, h, out_valid, busy);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_primes lo=%0d hi=%0d got_left=%0d exp_left=0", l, h, exp_q.size());
        end
        checks++;
        if (prime_cnt !== CNT_W'(n_p) || err !== is_err) begin
            failures++;
            $display("FAIL final_count lo=%0d hi=%0d cnt=%0d err=%b exp cnt=%0d err=%b",
                     l, h, prime_cnt, err, n_p, is_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
            prime_cnt !== CNT_W'(n_p) || err !== is_err) begin
            failures++;
            $display("FAIL idle_hold lo=%0d hi=%0d done=%b busy=%b valid=%b cnt=%0d err=%b exp 0 0 0 %0d %b",
                     l, h, done, busy, out_valid, prime_cnt, err, n_p, is_err);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        lo        = 4'd0;
        hi        = 4'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'd0 || prime_cnt !== '0 ||
            done !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_values busy=%b valid=%b data=%0d cnt=%0d done=%b err=%b st=%0d exp all 0",
                     busy, out_valid, out_data, prime_cnt, done, err, dbg_state);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b done=%b valid=%b exp 0 0 0", busy, done, out_valid);
        end
    endtask

    task automatic test_full_range();
        run_scan(4'd0, 4'd15, 0, 23);
    endtask

    task automatic test_empty_range();
        run_scan(4'd8, 4'd10, 0, 4);
    endtask

    task automatic test_error();
        run_scan(4'd5, 4'd3, 0, 1);
        // A valid start right after must clear err (checked at cycle 1).
        run_scan(4'd2, 4'd2, 0, 3);
    endtask

    task automatic test_backpressure();
        run_scan(4'd2, 4'd3, 2, 10);
    endtask

    task automatic test_single_value();
        run_scan(4'd13, 4'd13, 0, 3);
        run_scan(4'd15, 4'd15, 0, 2);
        run_scan(4'd1, 4'd1, 0, 2);
        run_scan(4'd4, 4'd4, 0, 2);
    endtask

    task automatic test_reset_mid_run();
        int  c;
        int  got;
        bit  seen7;
        bit  stray;
        start     = 1'b1;
        lo        = 4'd0;
        hi        = 4'd15;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 0;
        seen7 = 1'b0;
        c     = 1;
        while (c <= 60) begin
            if (out_valid === 1'b1 && out_data === 4'd7) begin
                seen7 = 1'b1;
                break;
            end
            if (out_valid === 1'b1) got++;
            // Start pulse while busy must be ignored.
            start = (c == 3);
            lo    = 4'd0;
            hi    = 4'd0;
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        checks++;
        if (!seen7 || got != 3 || prime_cnt !== CNT_W'(3)) begin
            failures++;
            $display("FAIL pre_reset_progress seen7=%b transfers=%0d cnt=%0d exp 1 3 3", seen7, got, prime_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'd0 || prime_cnt !== '0 ||
            done !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b valid=%b data=%0d cnt=%0d done=%b err=%b st=%0d exp all 0",
                     busy, out_valid, out_data, prime_cnt, done, err, dbg_state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL post_reset_quiet got=activity exp=idle");
        end
        run_scan(4'd0, 4'd15, 0, 23);
    endtask

    task automatic test_random();
        logic [3:0] l;
        logic [3:0] h;
        for (int i = 0; i < 20; i++) begin
            l = 4'($urandom_range(0, 15));
            h = 4'($urandom_range(0, 15));
            run_scan(l, h, 1, -1);
        end
    endtask

    task automatic test_back_to_back();
        run_scan(4'd0, 4'd7, 1, -1);
        run_scan(4'd9, 4'd15, 1, -1);
        run_scan(4'd15, 4'd0, 0, 1);
    endtask

    // Test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_range();
        test_empty_range();
        test_error();
        test_backpressure();
        test_single_value();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
